vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 15 +
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Frame-buffer address/data bus between the raster timing generator and
//   the pixel store.
//   master (timing generator): drives HC_O/VC_O, receives PIXEL_DATA.
//   slave  (frame buffer)    : receives HC_O/VC_O, returns PIXEL_DATA.
//   The return path is combinational: PIXEL_DATA belongs to the address
//   presented in the same cycle.
interface vga_timing_gen_if;
  logic [10:0] HC_O;        // horizontal scan count (frame buffer uses [9:0])
  logic [9:0]  VC_O;        // vertical scan count
  logic [7:0]  PIXEL_DATA;  // RGB332 pixel for (HC_O, VC_O)

  modport master (output HC_O, output VC_O, input PIXEL_DATA);
  modport slave  (input HC_O, input VC_O, output PIXEL_DATA);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing and pixel output stage of the VGA driver.
//   Stage 1: free-running horizontal/vertical scan counters that address the
//            frame buffer through the fb interface.
//   Stage 2: registered RGB332 pixel, DE, HSYNC, VSYNC and FRAME_START, all
//            derived from the stage-1 counts of the previous cycle so every
//            pin output is mutually aligned (one clock behind HC_O/VC_O).
//   Ports:
//     PIXEL_CLK   pixel clock, all state on rising edge
//     RST_N       synchronous active-low reset
//     fb          frame-buffer bus (HC_O, VC_O out; PIXEL_DATA in)
//     TP_SEL      test-pattern select (only with TEST_PATTERN_EN)
//     RED/GREEN/BLUE  blanked pixel colour to the DAC
//     HSYNC/VSYNC     syncs with H_POL/V_POL active level
//     DE              display enable, aligned with RGB
//     FRAME_START     one-cycle strobe aligned with pixel (0,0)
//   Build option:
//     TEST_PATTERN_EN  adds TP_SEL and an internal 8-bar colour pattern
//                      (bar = HC_O/100) as an alternate RGB source.
//   Legal timing: H_TOTAL <= 2048, V_TOTAL <= 1024.
module vga_timing_gen #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 56,
  parameter int H_SYNC = 120,
  parameter int H_BP   = 64,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 37,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 23,
  parameter bit H_POL  = 1'b1,
  parameter bit V_POL  = 1'b1
) (
  input  logic                PIXEL_CLK,
  input  logic                RST_N,
  vga_timing_gen_if.master    fb,
`ifdef TEST_PATTERN_EN
  input  logic                TP_SEL,
`endif
  output logic [2:0]          RED,
  output logic [2:0]          GREEN,
  output logic [1:0]          BLUE,
  output logic                HSYNC,
  output logic                VSYNC,
  output logic                DE,
  output logic                FRAME_START
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // ---------------- stage 1: scan counters ----------------
  logic [10:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + 11'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (!RST_N) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign fb.HC_O = hc_q;
  assign fb.VC_O = vc_q;

  // ---------------- stage 2: pin registers ----------------
  // Comparisons are done in int so sync window ends that reach H_TOTAL or
  // V_TOTAL (zero back porch) cannot overflow the counter width.
  logic       active;
  logic [7:0] pix;
  logic [7:0] rgb_q, rgb_d;
  logic       de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

`ifdef TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (int'(hc_q) >= 100 * k) bar = 3'(k);
  end
`endif

  always_comb begin
    pix = fb.PIXEL_DATA;
`ifdef TEST_PATTERN_EN
    if (TP_SEL) pix = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
`endif
    active = (int'(hc_q) < H_VIS) && (int'(vc_q) < V_VIS);
    rgb_d  = active ? pix : 8'h00;
    de_d   = active;
    hs_d   = ((int'(hc_q) >= H_VIS + H_FP) && (int'(hc_q) < H_VIS + H_FP + H_SYNC))
             ? H_POL : ~H_POL;
    // VSYNC only depends on VC_O, which changes at HC_O wrap, so it moves on
    // the line boundary automatically.
    vs_d   = ((int'(vc_q) >= V_VIS + V_FP) && (int'(vc_q) < V_VIS + V_FP + V_SYNC))
             ? V_POL : ~V_POL;
    fs_d   = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (!RST_N) begin
      rgb_q <= 8'h00;
      de_q  <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  assign RED         = rgb_q[7:5];
  assign GREEN       = rgb_q[4:2];
  assign BLUE        = rgb_q[1:0];
  assign DE          = de_q;
  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign FRAME_START = fs_q;

endmodule
